phy_link_mgr: RTL
=================

# phy_link_mgr

Upstream sequencer for the MDIO driver: it sits between the Ethernet top level and the MDIO driver's command port. After reset it soft-resets the 88E1111-class PHY through MDIO and waits for the reset to self-clear. It then polls the basic and PHY-specific status registers periodically and publishes link state, speed and duplex to the MAC/UDP datapath. It runs entirely in the driver's dri_clk domain.

## Interface
- PWRUP_CYCLES, 16'd50000: wait after rst release before first MDIO op (10 ms at 5 MHz).
- POLL_CYCLES, 24'd500000: idle gap between status poll rounds (100 ms).
- OP_TIMEOUT, 10'd512: max cycles from op_exec to op_done.
- RST_POLL_MAX, 8'd64: max reg0 reads waiting for soft-reset self-clear.
- clk  in  1  dri_clk output of the MDIO driver; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- soft_rst_req  in  1  one-cycle pulse: re-run the PHY soft-reset sequence.
- op_exec  out  1  one-cycle command strobe to the driver.
- op_rh_wl  out  1  1 = read, 0 = write.
- op_addr  out  5  PHY register address.
- op_wr_data  out  16  write data.
- op_done  in  1  one-cycle completion pulse from the driver.
- op_rd_data  in  16  read data, valid in the op_done cycle.
- op_rd_ack  in  1  0 = PHY answered the read, sampled in the op_done cycle.
- init_done  out  1  soft reset completed; polling is active.
- init_err  out  1  sticky: soft-reset sequence failed; cleared only by rst or soft_rst_req.
- link_up  out  1  link up and autoneg resolved.
- speed  out  2  00 = 10M, 01 = 100M, 10 = 1000M (PHYSR[15:14]).
- full_duplex  out  1  PHYSR[13].

## Operation
- Reset values: op_exec=0, op_rh_wl=1, op_addr=0, op_wr_data=0, init_done=0, init_err=0, link_up=0, speed=00, full_duplex=0. The state machine resets to PWRUP.
- **PWRUP**: count PWRUP_CYCLES, then go to SRST_WR.
- **SRST_WR**: write reg 0 = 16'h9140 (reset, AN enable, full duplex, 1000M), then go to SRST_RD.
- **SRST_RD**: read reg 0.
  - bit15 = 0 and rd_ack = 0: set init_done=1 and go to POLL_WAIT.
  - Otherwise: increment the poll counter and read again.
  - After RST_POLL_MAX reads, or on any op timeout in SRST_WR/SRST_RD: set init_err=1 and go to HALT.
- **POLL_WAIT**: count POLL_CYCLES, then go to RD_BMSR.
- **RD_BMSR**: read reg 1.
  - If rd_ack=1, timeout, BMSR[2]=0 or BMSR[5]=0: link_up=0, speed=00, full_duplex=0, then POLL_WAIT.
  - Otherwise go to RD_PHYSR.
- **RD_PHYSR**: read reg 17.
  - If PHYSR[11]=1 (resolved) and rd_ack=0: link_up=1, speed=PHYSR[15:14], full_duplex=PHYSR[13].
  - Otherwise clear all three.
  - Return to POLL_WAIT.
- **HALT**: idle; only soft_rst_req or rst leaves.
- Every MDIO op uses an ISSUE/WAIT sub-sequence:
  - ISSUE drives op_exec=1 for exactly one cycle.
  - op_addr, op_rh_wl and op_wr_data are loaded in the ISSUE cycle and held unchanged until op_done; the driver samples address and data late.
  - WAIT holds until op_done, or until the timeout counter reaches OP_TIMEOUT.
- speed=11 from the PHY is passed through unchanged.
- soft_rst_req:
  - In PWRUP, POLL_WAIT or HALT: act next cycle. Clear init_done, init_err, link_up, speed, full_duplex and go to SRST_WR.
  - While an op is in flight: latch it as pending and act after op_done or timeout. Never abort a driver transaction.
  - A second request while one is pending is merged.

## Timing
- op_exec rises the cycle after entry to an op state. It is never asserted while a previous op awaits op_done, and never in two consecutive cycles.
- Status outputs update on the clock edge after the op_done cycle: one cycle of latency from op_done.
- Minimum gap from op_done to the next op_exec is 2 cycles; the driver must return to idle first.
- Timeout: counted from the op_exec cycle. In the cycle where the count equals OP_TIMEOUT, the block leaves WAIT, and any late op_done is ignored.
- Asynchronous rst mid-op: all outputs return to reset values immediately and the sequence restarts at PWRUP.

## Test plan
- Power-up, model PHY clears reg0 bit15 on the 3rd read:
  - Expect op_exec after PWRUP_CYCLES, then write addr 0 data 16'h9140, then 3 reads of reg 0.
  - init_done=1 one cycle after the 3rd op_done.
- Link up, BMSR=16'h796D and PHYSR=16'hAC00:
  - link_up=1, speed=10, full_duplex=1 one cycle after the PHYSR op_done.
- Link drop, next BMSR=16'h7969:
  - No reg 17 read; link_up=0, speed=00, full_duplex=0.
- Reset never clears (reg0 always 16'h9140):
  - Exactly RST_POLL_MAX reads, then init_err=1, init_done=0, no further op_exec.
  - soft_rst_req then restarts the sequence at the reg 0 write.
- Driver never returns op_done:
  - Timeout after OP_TIMEOUT cycles gives init_err=1.
  - In the poll phase, the same timeout gives link_up=0 and the next round starts after POLL_CYCLES.
- Edge cases:
  - soft_rst_req pulsed mid-read: op completes first, and op_addr stays stable until op_done.
  - rst asserted mid-op: all outputs return to reset values immediately.

Source files
------------

// File: rtl/phy_link_mgr_if.sv
// MDIO driver command port and link-status publish signals for phy_link_mgr.
// master = sequencer side, slave = driver / datapath side.
interface phy_link_mgr_if;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;

    logic              soft_rst_req;
    logic              op_exec;
    logic              op_rh_wl;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wr_data;
    logic              op_done;
    logic [DATA_W-1:0] op_rd_data;
    logic              op_rd_ack;
    logic              init_done;
    logic              init_err;
    logic              link_up;
    logic [1:0]        speed;
    logic              full_duplex;

    modport master (
        input  soft_rst_req, op_done, op_rd_data, op_rd_ack,
        output op_exec, op_rh_wl, op_addr, op_wr_data,
        output init_done, init_err, link_up, speed, full_duplex
    );

    modport slave (
        output soft_rst_req, op_done, op_rd_data, op_rd_ack,
        input  op_exec, op_rh_wl, op_addr, op_wr_data,
        input  init_done, init_err, link_up, speed, full_duplex
    );
endinterface

// File: rtl/phy_link_mgr.sv
// PHY bring-up and link-status poller sitting in front of the MDIO driver.
// Soft-resets the PHY, then polls BMSR/PHYSR and publishes link, speed, duplex.
module phy_link_mgr #(
    parameter logic [15:0] PWRUP_CYCLES = 16'd50000,
    parameter logic [23:0] POLL_CYCLES  = 24'd500000,
    parameter logic [9:0]  OP_TIMEOUT   = 10'd512,
    parameter logic [7:0]  RST_POLL_MAX = 8'd64
) (
    input  logic           clk,
    input  logic           rst,
    phy_link_mgr_if.master bus
);
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned POLL_W = 8;

    localparam logic [ADDR_W-1:0] REG_BMCR      = 5'd0;
    localparam logic [ADDR_W-1:0] REG_BMSR      = 5'd1;
    localparam logic [ADDR_W-1:0] REG_PHYSR     = 5'd17;
    localparam logic [DATA_W-1:0] BMCR_SOFT_RST = 16'h9140;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_SRST_WR_ISSUE,
        S_SRST_WR_WAIT,
        S_SRST_RD_ISSUE,
        S_SRST_RD_WAIT,
        S_POLL_WAIT,
        S_BMSR_ISSUE,
        S_BMSR_WAIT,
        S_PHYSR_ISSUE,
        S_PHYSR_WAIT,
        S_HALT
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [POLL_W-1:0]   rst_polls, rst_polls_nxt;
    logic                rst_pend, rst_pend_nxt;

    logic                op_exec_q, op_exec_nxt;
    logic                op_rh_wl_q, op_rh_wl_nxt;
    logic [ADDR_W-1:0]   op_addr_q, op_addr_nxt;
    logic [DATA_W-1:0]   op_wr_data_q, op_wr_data_nxt;
    logic                init_done_q, init_done_nxt;
    logic                init_err_q, init_err_nxt;
    logic                link_up_q, link_up_nxt;
    logic [1:0]          speed_q, speed_nxt;
    logic                full_duplex_q, full_duplex_nxt;

    logic                waiting;
    logic                in_op;
    logic                op_timeout;
    logic                op_end;
    logic                rd_ok;
    logic                restart;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_PWRUP;
            cnt           <= '0;
            rst_polls     <= '0;
            rst_pend      <= 1'b0;
            op_exec_q     <= 1'b0;
            op_rh_wl_q    <= 1'b1;
            op_addr_q     <= '0;
            op_wr_data_q  <= '0;
            init_done_q   <= 1'b0;
            init_err_q    <= 1'b0;
            link_up_q     <= 1'b0;
            speed_q       <= 2'b00;
            full_duplex_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            rst_polls     <= rst_polls_nxt;
            rst_pend      <= rst_pend_nxt;
            op_exec_q     <= op_exec_nxt;
            op_rh_wl_q    <= op_rh_wl_nxt;
            op_addr_q     <= op_addr_nxt;
            op_wr_data_q  <= op_wr_data_nxt;
            init_done_q   <= init_done_nxt;
            init_err_q    <= init_err_nxt;
            link_up_q     <= link_up_nxt;
            speed_q       <= speed_nxt;
            full_duplex_q <= full_duplex_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt + CNT_W'(1);
        rst_polls_nxt   = rst_polls;
        rst_pend_nxt    = rst_pend;
        op_exec_nxt     = 1'b0;
        op_rh_wl_nxt    = op_rh_wl_q;
        op_addr_nxt     = op_addr_q;
        op_wr_data_nxt  = op_wr_data_q;
        init_done_nxt   = init_done_q;
        init_err_nxt    = init_err_q;
        link_up_nxt     = link_up_q;
        speed_nxt       = speed_q;
        full_duplex_nxt = full_duplex_q;

        waiting    = state inside {S_SRST_WR_WAIT, S_SRST_RD_WAIT, S_BMSR_WAIT, S_PHYSR_WAIT};
        in_op      = waiting || (state inside {S_SRST_WR_ISSUE, S_SRST_RD_ISSUE,
                                               S_BMSR_ISSUE, S_PHYSR_ISSUE});
        // cnt is 1 in the op_exec cycle, so WAIT lasts at most OP_TIMEOUT cycles
        op_timeout = waiting && !bus.op_done && (cnt == CNT_W'(OP_TIMEOUT));
        op_end     = waiting && (bus.op_done || op_timeout);
        rd_ok      = bus.op_done && !bus.op_rd_ack;

        case (state)
            S_PWRUP: begin
                if (cnt + CNT_W'(1) >= CNT_W'(PWRUP_CYCLES)) begin
                    state_nxt = S_SRST_WR_ISSUE;
                    cnt_nxt   = '0;
                end
            end
            S_SRST_WR_ISSUE: begin
                op_exec_nxt    = 1'b1;
                op_rh_wl_nxt   = 1'b0;
                op_addr_nxt    = REG_BMCR;
                op_wr_data_nxt = BMCR_SOFT_RST;
                state_nxt      = S_SRST_WR_WAIT;
                cnt_nxt        = CNT_W'(1);
            end
            S_SRST_WR_WAIT: begin
                if (op_end) begin
                    cnt_nxt = '0;
                    if (op_timeout) begin
                        init_err_nxt = 1'b1;
                        state_nxt    = S_HALT;
                    end else begin
                        state_nxt = S_SRST_RD_ISSUE;
                    end
                end
            end
            S_SRST_RD_ISSUE: begin
                op_exec_nxt    = 1'b1;
                op_rh_wl_nxt   = 1'b1;
                op_addr_nxt    = REG_BMCR;
                op_wr_data_nxt = '0;
                state_nxt      = S_SRST_RD_WAIT;
                cnt_nxt        = CNT_W'(1);
            end
            S_SRST_RD_WAIT: begin
                if (op_end) begin
                    cnt_nxt = '0;
                    if (op_timeout) begin
                        init_err_nxt = 1'b1;
                        state_nxt    = S_HALT;
                    end else if (rd_ok && !bus.op_rd_data[15]) begin
                        init_done_nxt = 1'b1;
                        state_nxt     = S_POLL_WAIT;
                    end else if (rst_polls + POLL_W'(1) == RST_POLL_MAX) begin
                        init_err_nxt = 1'b1;
                        state_nxt    = S_HALT;
                    end else begin
                        rst_polls_nxt = rst_polls + POLL_W'(1);
                        state_nxt     = S_SRST_RD_ISSUE;
                    end
                end
            end
            S_POLL_WAIT: begin
                if (cnt + CNT_W'(1) >= POLL_CYCLES) begin
                    state_nxt = S_BMSR_ISSUE;
                    cnt_nxt   = '0;
                end
            end
            S_BMSR_ISSUE: begin
                op_exec_nxt    = 1'b1;
                op_rh_wl_nxt   = 1'b1;
                op_addr_nxt    = REG_BMSR;
                op_wr_data_nxt = '0;
                state_nxt      = S_BMSR_WAIT;
                cnt_nxt        = CNT_W'(1);
            end
            S_BMSR_WAIT: begin
                if (op_end) begin
                    cnt_nxt = '0;
                    // Link status and AN complete both required before reading PHYSR
                    if (rd_ok && bus.op_rd_data[2] && bus.op_rd_data[5]) begin
                        state_nxt = S_PHYSR_ISSUE;
                    end else begin
                        link_up_nxt     = 1'b0;
                        speed_nxt       = 2'b00;
                        full_duplex_nxt = 1'b0;
                        state_nxt       = S_POLL_WAIT;
                    end
                end
            end
            S_PHYSR_ISSUE: begin
                op_exec_nxt    = 1'b1;
                op_rh_wl_nxt   = 1'b1;
                op_addr_nxt    = REG_PHYSR;
                op_wr_data_nxt = '0;
                state_nxt      = S_PHYSR_WAIT;
                cnt_nxt        = CNT_W'(1);
            end
            S_PHYSR_WAIT: begin
                if (op_end) begin
                    cnt_nxt   = '0;
                    state_nxt = S_POLL_WAIT;
                    if (rd_ok && bus.op_rd_data[11]) begin
                        link_up_nxt     = 1'b1;
                        speed_nxt       = bus.op_rd_data[15:14];
                        full_duplex_nxt = bus.op_rd_data[13];
                    end else begin
                        link_up_nxt     = 1'b0;
                        speed_nxt       = 2'b00;
                        full_duplex_nxt = 1'b0;
                    end
                end
            end
            S_HALT: begin
                cnt_nxt = '0;
            end
            default: begin
                state_nxt = S_PWRUP;
                cnt_nxt   = '0;
            end
        endcase

        // A request during a driver transaction waits for it to end; repeats merge
        if (in_op && bus.soft_rst_req) begin
            rst_pend_nxt = 1'b1;
        end
        restart = (!in_op && bus.soft_rst_req) || (op_end && (rst_pend || bus.soft_rst_req));
        if (restart) begin
            state_nxt       = S_SRST_WR_ISSUE;
            cnt_nxt         = '0;
            rst_polls_nxt   = '0;
            rst_pend_nxt    = 1'b0;
            init_done_nxt   = 1'b0;
            init_err_nxt    = 1'b0;
            link_up_nxt     = 1'b0;
            speed_nxt       = 2'b00;
            full_duplex_nxt = 1'b0;
        end
    end

    assign bus.op_exec     = op_exec_q;
    assign bus.op_rh_wl    = op_rh_wl_q;
    assign bus.op_addr     = op_addr_q;
    assign bus.op_wr_data  = op_wr_data_q;
    assign bus.init_done   = init_done_q;
    assign bus.init_err    = init_err_q;
    assign bus.link_up     = link_up_q;
    assign bus.speed       = speed_q;
    assign bus.full_duplex = full_duplex_q;
endmodule
